// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg
//   Shared constants for the scanned seven-segment frame decoder:
//   segment patterns (active-low, {g,f,e,d,c,b,a}), scanner state
//   encoding, output widths and the BCD-to-binary helper.
package seg_scan_decoder_pkg;

    localparam int SCORE_W = 11;
    localparam int BCD_W   = 4;

    // Active-low segment patterns for digits 0..9.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Scanner states.
    localparam logic [0:0] ST_SYNC    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    // d3*1000 + d2*100 + d1*10 + d0 built from shifted adds:
    //   1000 = 512+256+128+64+32+8, 100 = 64+32+4, 10 = 8+2.
    function automatic logic [13:0] bcd_to_bin(
        input logic [3:0] d3,
        input logic [3:0] d2,
        input logic [3:0] d1,
        input logic [3:0] d0
    );
        logic [13:0] e3, e2, e1, e0;
        e3 = {10'b0, d3};
        e2 = {10'b0, d2};
        e1 = {10'b0, d1};
        e0 = {10'b0, d0};
        return (e3 << 9) + (e3 << 8) + (e3 << 7) + (e3 << 6) + (e3 << 5) + (e3 << 3)
             + (e2 << 6) + (e2 << 5) + (e2 << 2)
             + (e1 << 3) + (e1 << 1)
             + e0;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_pattern.sv
// seg_pattern_decoder
//   Combinational inverse of the seven-segment encoder.
//   Ports:
//     seg   in  [6:0] active-low pattern {g,f,e,d,c,b,a}
//     value out [3:0] decoded digit (0 when not a digit pattern)
//     ok    out       high when seg is one of the ten digit patterns
module seg_pattern_decoder
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       ok
);

    always_comb begin
        value = '0;
        ok    = 1'b1;
        case (seg)
            SEG_0: value = 4'd0;
            SEG_1: value = 4'd1;
            SEG_2: value = 4'd2;
            SEG_3: value = 4'd3;
            SEG_4: value = 4'd4;
            SEG_5: value = 4'd5;
            SEG_6: value = 4'd6;
            SEG_7: value = 4'd7;
            SEG_8: value = 4'd8;
            SEG_9: value = 4'd9;
            default: ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Snoops a multiplexed 4-digit seven-segment display and recovers the
//   displayed number. A frame is digits 0,1,2,3 in scan order; a complete,
//   well-formed frame of value <= 2047 is registered, anything else pulses err.
//   Ports:
//     clk_400    in        scan clock (same clock as the display mux)
//     rst        in        asynchronous active-high reset
//     seg        in  [7:0] active-low segments, seg[7]=dp (ignored)
//     an         in  [3:0] active-low digit enables, an[0]=ones
//     score      out [10:0] last accepted value, binary
//     digits     out [15:0] last accepted value, BCD {d3,d2,d1,d0}
//     valid      out       a frame has been accepted since reset
//     frame_done out       pulse per accepted frame
//     changed    out       pulse when accepted value differs (or first frame)
//     err        out       pulse per rejected frame
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
(
    input  logic                 clk_400,
    input  logic                 rst,
    input  logic [7:0]           seg,
    input  logic [3:0]           an,
    output logic [SCORE_W-1:0]   score,
    output logic [4*BCD_W-1:0]   digits,
    output logic                 valid,
    output logic                 frame_done,
    output logic                 changed,
    output logic                 err
);

    logic [0:0]       state_q;
    logic [1:0]       exp_q;
    logic [2:0]       tmo_q;
    logic             bad_q;
    logic [BCD_W-1:0] d0_q, d1_q, d2_q;

    logic             active;
    logic [1:0]       idx;
    logic [3:0]       dec_val;
    logic             dec_ok;
    logic             frame_bad;
    logic [13:0]      frame_val;
    logic             unused_dp;

    assign unused_dp = seg[7];

    seg_pattern_decoder u_pattern (
        .seg   (seg[6:0]),
        .value (dec_val),
        .ok    (dec_ok)
    );

    // Exactly one low enable selects a digit; anything else is idle.
    always_comb begin
        active = 1'b0;
        idx    = '0;
        case (an)
            4'b1110: begin active = 1'b1; idx = 2'd0; end
            4'b1101: begin active = 1'b1; idx = 2'd1; end
            4'b1011: begin active = 1'b1; idx = 2'd2; end
            4'b0111: begin active = 1'b1; idx = 2'd3; end
            default: ;
        endcase
    end

    // Index 3 is never stored; it is folded straight into the value.
    assign frame_bad = bad_q | ~dec_ok;
    assign frame_val = bcd_to_bin(dec_val, d2_q, d1_q, d0_q);

    always_ff @(posedge clk_400 or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SYNC;
            exp_q      <= '0;
            tmo_q      <= '0;
            bad_q      <= 1'b0;
            d0_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            score      <= '0;
            digits     <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            changed    <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            changed    <= 1'b0;
            err        <= 1'b0;
            case (state_q)
                ST_SYNC: begin
                    if (active && idx == 2'd0) begin
                        d0_q    <= dec_val;
                        bad_q   <= ~dec_ok;
                        exp_q   <= 2'd1;
                        tmo_q   <= '0;
                        state_q <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!active) begin
                        // Seventh consecutive idle cycle abandons the frame.
                        if (tmo_q == 3'd6) begin
                            err     <= 1'b1;
                            state_q <= ST_SYNC;
                            exp_q   <= '0;
                            tmo_q   <= '0;
                            bad_q   <= 1'b0;
                        end else begin
                            tmo_q <= tmo_q + 3'd1;
                        end
                    end else if (idx == exp_q) begin
                        tmo_q <= '0;
                        case (idx)
                            2'd1:    d1_q <= dec_val;
                            2'd2:    d2_q <= dec_val;
                            default: ;
                        endcase
                        if (idx == 2'd3) begin
                            state_q <= ST_SYNC;
                            exp_q   <= '0;
                            bad_q   <= 1'b0;
                            if (frame_bad || frame_val > 14'd2047) begin
                                err <= 1'b1;
                            end else begin
                                score      <= frame_val[SCORE_W-1:0];
                                digits     <= {dec_val, d2_q, d1_q, d0_q};
                                valid      <= 1'b1;
                                frame_done <= 1'b1;
                                changed    <= !valid || (frame_val[SCORE_W-1:0] != score);
                            end
                        end else begin
                            exp_q <= exp_q + 2'd1;
                            bad_q <= frame_bad;
                        end
                    end else begin
                        // Out-of-order digit: reject; a fresh index 0 restarts.
                        err   <= 1'b1;
                        tmo_q <= '0;
                        if (idx == 2'd0) begin
                            d0_q  <= dec_val;
                            bad_q <= ~dec_ok;
                            exp_q <= 2'd1;
                        end else begin
                            state_q <= ST_SYNC;
                            exp_q   <= '0;
                            bad_q   <= 1'b0;
                        end
                    end
                end
                default: state_q <= ST_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Directed scenarios followed by randomized scan traffic, compared each
//   cycle against a frame-level reference model.
module tb_seg_scan_decoder;

    logic        clk_400 = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [10:0] score;
    logic [15:0] digits;
    logic        valid, frame_done, changed, err;

    int tests = 0;
    int fails = 0;

    seg_scan_decoder dut (
        .clk_400    (clk_400),
        .rst        (rst),
        .seg        (seg),
        .an         (an),
        .score      (score),
        .digits     (digits),
        .valid      (valid),
        .frame_done (frame_done),
        .changed    (changed),
        .err        (err)
    );

    always #5 clk_400 = ~clk_400;

    logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    logic [3:0] idle_an [8] = '{4'hF, 4'h0, 4'hC, 4'h3, 4'hA, 4'h9, 4'h5, 4'h6};

    // Reference model: the partial frame is a list of captured digits.
    int       m_len;
    int       m_vals [4];
    bit       m_oks [4];
    int       m_idle;
    int       m_score;
    bit       m_valid;
    logic [3:0] m_dig [4];
    bit       e_done, e_chg, e_err;

    task automatic model_reset();
        m_len = 0; m_idle = 0; m_score = 0; m_valid = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = '0;
        e_done = 0; e_chg = 0; e_err = 0;
    endtask

    task automatic model_step(input logic [3:0] a, input logic [7:0] s);
        int zeros = 0;
        int idx = -1;
        int val = 0;
        bit ok = 0;
        int v;
        e_done = 0; e_chg = 0; e_err = 0;
        for (int i = 0; i < 4; i++) if (a[i] == 1'b0) begin zeros++; idx = i; end
        for (int k = 0; k < 10; k++) if (s[6:0] == pat[k]) begin ok = 1; val = k; end
        if (zeros != 1) begin
            if (m_len > 0) begin
                m_idle++;
                if (m_idle == 7) begin e_err = 1; m_len = 0; m_idle = 0; end
            end
            return;
        end
        m_idle = 0;
        if (m_len == 0) begin
            if (idx == 0) begin m_vals[0] = val; m_oks[0] = ok; m_len = 1; end
        end else if (idx == m_len) begin
            m_vals[idx] = val; m_oks[idx] = ok; m_len++;
            if (m_len == 4) begin
                m_len = 0;
                v = 1000 * m_vals[3] + 100 * m_vals[2] + 10 * m_vals[1] + m_vals[0];
                if (m_oks[0] && m_oks[1] && m_oks[2] && m_oks[3] && v <= 2047) begin
                    e_done = 1;
                    e_chg  = !m_valid || (v != m_score);
                    m_score = v;
                    m_valid = 1;
                    for (int i = 0; i < 4; i++) m_dig[i] = 4'(m_vals[i]);
                end else begin
                    e_err = 1;
                end
            end
        end else begin
            e_err = 1;
            if (idx == 0) begin m_vals[0] = val; m_oks[0] = ok; m_len = 1; end
            else m_len = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ":score"},      32'(score),      32'(m_score));
        check({tag, ":digits"},     32'(digits),     32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        check({tag, ":valid"},      32'(valid),      32'(m_valid));
        check({tag, ":frame_done"}, 32'(frame_done), 32'(e_done));
        check({tag, ":changed"},    32'(changed),    32'(e_chg));
        check({tag, ":err"},        32'(err),        32'(e_err));
        check({tag, ":done_err_excl"}, 32'(frame_done & err), 32'(0));
    endtask

    function automatic logic [7:0] segof(input int d);
        logic dp;
        dp = 1'($urandom_range(0, 1));
        return {dp, pat[d]};
    endfunction

    function automatic logic [3:0] anof(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    task automatic cycle(input string tag, input logic [3:0] a, input logic [7:0] s);
        an = a; seg = s;
        model_step(a, s);
        @(posedge clk_400);
        #1;
        check_outputs(tag);
    endtask

    task automatic send_frame(input string tag, input int a0, input int a1, input int a2, input int a3);
        cycle(tag, anof(0), segof(a0));
        cycle(tag, anof(1), segof(a1));
        cycle(tag, anof(2), segof(a2));
        cycle(tag, anof(3), segof(a3));
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        an = 4'hF; seg = 8'hFF;
        @(posedge clk_400);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int r, n, bad_i;
        int dv [4];
        rst = 1'b1; an = 4'hF; seg = 8'hFF;
        model_reset();
        #2;
        check_outputs("reset_async");
        @(posedge clk_400);
        #1;
        rst = 1'b0;

        // 7,2,0,1 in scan order -> 1027
        send_frame("f1027", 7, 2, 0, 1);
        check("f1027_score", 32'(score), 32'd1027);
        check("f1027_digits", 32'(digits), 32'h1027);

        // Back-to-back repeats from a fresh reset: changed only on the first.
        do_reset("reset_b2b");
        send_frame("b2b_a", 7, 2, 0, 1);
        check("b2b_a_changed", 32'(changed), 32'd1);
        send_frame("b2b_b", 7, 2, 0, 1);
        check("b2b_b_done", 32'(frame_done), 32'd1);
        check("b2b_b_changed", 32'(changed), 32'd0);

        // 2100 exceeds the score range.
        send_frame("over", 0, 0, 1, 2);
        check("over_err", 32'(err), 32'd1);
        check("over_hold", 32'(score), 32'd1027);

        // Index 0 then index 2 -> reject, then 345.
        cycle("skip0", anof(0), segof(5));
        cycle("skip2", anof(2), segof(3));
        check("skip_err", 32'(err), 32'd1);
        send_frame("f345", 5, 4, 3, 0);
        check("f345_score", 32'(score), 32'd345);

        // Timeout after seven idle cycles.
        cycle("to_d0", anof(0), segof(1));
        cycle("to_d1", anof(1), segof(2));
        for (int i = 0; i < 7; i++) cycle("to_idle", 4'hF, 8'hFF);
        check("timeout_err", 32'(err), 32'd1);
        send_frame("f1999", 9, 9, 9, 1);
        check("f1999_score", 32'(score), 32'd1999);

        // Blank pattern at index 1 -> reject at index 3.
        cycle("bad_d0", anof(0), segof(1));
        cycle("bad_d1", anof(1), 8'hFF);
        cycle("bad_d2", anof(2), segof(1));
        cycle("bad_d3", anof(3), segof(1));
        check("badpat_err", 32'(err), 32'd1);

        // Reset mid-frame: outputs clear at once, no err afterwards.
        cycle("mid_d0", anof(0), segof(3));
        cycle("mid_d1", anof(1), segof(4));
        do_reset("reset_mid");
        cycle("post_rst_idle", 4'hF, 8'hFF);
        check("post_rst_err", 32'(err), 32'd0);

        // Randomized traffic.
        for (n = 0; n < 400; n++) begin
            r = $urandom_range(0, 7);
            case (r)
                0, 1, 2, 3, 7: begin
                    for (int i = 0; i < 3; i++) dv[i] = $urandom_range(0, 9);
                    dv[3] = $urandom_range(0, 2);
                    bad_i = (r == 7) ? $urandom_range(0, 3) : -1;
                    for (int i = 0; i < 4; i++) begin
                        if ($urandom_range(0, 5) == 0) begin
                            for (int k = 0; k < $urandom_range(1, 3); k++)
                                cycle("rnd_gap", idle_an[$urandom_range(0, 7)], 8'($urandom));
                        end
                        if (i == bad_i) cycle("rnd_bad", anof(i), 8'($urandom));
                        else            cycle("rnd_frame", anof(i), segof(dv[i]));
                    end
                end
                4: cycle("rnd_any", 4'($urandom), 8'($urandom));
                5: cycle("rnd_digit", anof($urandom_range(0, 3)), segof($urandom_range(0, 9)));
                default: begin
                    for (int k = 0; k < $urandom_range(1, 9); k++)
                        cycle("rnd_idle", 4'hF, 8'hFF);
                end
            endcase
            if ($urandom_range(0, 99) == 0) do_reset("rnd_reset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
